event_router_rr: RTL

- Parametrised successor to the chip's event router: arbitrates among NUMCHANNELS per-channel local FIFOs and moves one event at a time into the shared FIFO.
- Adds selectable fixed-priority or round-robin arbitration, a per-channel router mask, shared-FIFO backpressure and a routed-event counter.
- Sits between the channel_ctrl instances (local FIFO outputs) and the shared FIFO write port.

---
 rtl/event_router_rr.sv | 131 +++++++++++++
 1 files changed

// File: rtl/event_router_rr.sv
// Event router: arbitrates NUMCHANNELS local FIFOs (fixed priority or round-robin)
// and moves one event per three cycles into the shared FIFO.
module event_router_rr #(
  parameter int WIDTH       = 64,
  parameter int NUMCHANNELS = 64,
  parameter int CNT_W       = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUMCHANNELS*(WIDTH-1)-1:0]   input_event,
  input  logic [NUMCHANNELS-1:0]             local_fifo_empty,
  input  logic [NUMCHANNELS-1:0]             router_mask,
  input  logic                               arb_mode,
  input  logic                               fifo_full,
  output logic [NUMCHANNELS-1:0]             read_local_fifo_n,
  output logic [WIDTH-2:0]                   channel_event_out,
  output logic                               load_event,
  output logic [$clog2(NUMCHANNELS)-1:0]     grant_id,
  output logic                               busy,
  output logic [CNT_W-1:0]                   events_routed
);
  localparam int EW  = WIDTH - 1;
  localparam int IDW = $clog2(NUMCHANNELS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [NUMCHANNELS-1:0] strobe_q, strobe_d;
  logic [EW-1:0]          data_q, data_d;
  logic                   load_q, load_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [EW-1:0]          ev [NUMCHANNELS];
  logic [NUMCHANNELS-1:0] elig;
  logic                   found_fp, found_rr;
  logic [IDW-1:0]         win_fp, win_rr, win, win_next;
  int unsigned            idx;

  for (genvar g = 0; g < NUMCHANNELS; g++) begin : g_unpack
    assign ev[g] = input_event[g*EW +: EW];
  end

  // Both arbiters evaluate every cycle; arb_mode only selects the result.
  always_comb begin
    elig     = ~local_fifo_empty & ~router_mask;
    found_fp = 1'b0;
    win_fp   = '0;
    found_rr = 1'b0;
    win_rr   = '0;
    idx      = 0;
    for (int unsigned i = 0; i < NUMCHANNELS; i++) begin
      if (elig[IDW'(i)] && !found_fp) begin
        found_fp = 1'b1;
        win_fp   = IDW'(i);
      end
    end
    for (int unsigned k = 0; k < NUMCHANNELS; k++) begin
      idx = (32'(ptr_q) + k) % NUMCHANNELS;
      if (elig[IDW'(idx)] && !found_rr) begin
        found_rr = 1'b1;
        win_rr   = IDW'(idx);
      end
    end
    win      = arb_mode ? win_rr : win_fp;
    win_next = (win == IDW'(NUMCHANNELS - 1)) ? '0 : win + IDW'(1);
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    strobe_d = '1;
    data_d   = data_q;
    load_d   = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found_fp && !fifo_full) begin
          strobe_d[win] = 1'b0;
          grant_d       = win;
          ptr_d         = win_next;
          state_d       = S_READ;
        end
      end
      S_READ: begin
        data_d  = ev[grant_q];
        load_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      strobe_q <= '1;
      data_q   <= '0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign read_local_fifo_n = strobe_q;
  assign channel_event_out = data_q;
  assign load_event        = load_q;
  assign grant_id          = grant_q;
  assign busy              = busy_q;
  assign events_routed     = cnt_q;

endmodule
